// File: rtl/elevator.sv
// Single-car collective elevator controller: latches car/hall calls, picks a
// travel direction and sequences engine and door actuators from plant feedback.
module elevator #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int DELAY_IDLE    = 5000,
    parameter int DELAY_WAIT    = 500,
    parameter int DELAY_OPEN    = 6000
) (
    input  logic                     clock,
    input  logic                     an_reset,
    input  logic                     buttons_block,
    input  logic                     open_btn,
    input  logic                     close_btn,
    input  logic                     overload,
    input  logic                     bell,
    input  logic                     sensor_up,
    input  logic                     sensor_down,
    input  logic                     sensor_inside,
    input  logic [1:0]               sensor_door,
    input  logic [BUTTONS_WIDTH-1:0] btn_in,
    input  logic [BUTTONS_WIDTH-2:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:1] btn_down_out,
    output logic [1:0]               engine,
    output logic [1:0]               door,
    output logic                     direction,
    output logic                     bell_out,
    output logic [3:0]               level_display
);
    localparam int N    = BUTTONS_WIDTH;
    localparam int TM1  = (DELAY_IDLE > DELAY_WAIT) ? DELAY_IDLE : DELAY_WAIT;
    localparam int TMAX = (TM1 > DELAY_OPEN) ? TM1 : DELAY_OPEN;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [3:0]    TOP    = 4'(N - 1);
    localparam logic [TW-1:0] T_IDLE = TW'(DELAY_IDLE - 1);
    localparam logic [TW-1:0] T_WAIT = TW'(DELAY_WAIT - 1);
    localparam logic [TW-1:0] T_OPEN = TW'(DELAY_OPEN - 1);

    typedef enum logic [2:0] {IDLE, CLOSE, MOVE, WAIT, OPEN_D, DWELL} state_t;

    state_t          state_q, state_d;
    logic [3:0]      level_q, level_d;
    logic            dir_q, dir_d;
    logic            moved_q, moved_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      engine_q, engine_d;
    logic [1:0]      door_q, door_d;
    logic            bell_out_q, bell_out_d;
    logic [N-1:0]    req_in_q, req_in_d;
    logic [N-2:0]    req_up_q, req_up_d;
    logic [N-1:1]    req_dn_q, req_dn_d;
    logic [N-1:0]    in_prev_q, in_prev_d;
    logic [N-2:0]    up_prev_q, up_prev_d;
    logic [N-1:1]    dn_prev_q, dn_prev_d;

    logic [N-1:0]    rise_in, calls, press;
    logic [N-2:0]    rise_up;
    logic [N-1:1]    rise_dn;
    logic            stopped, here_press, serve, arrive, clr_up, clr_dn;
    logic [3:0]      nf;

    function automatic logic bit_at(input logic [N-1:0] v, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N; i++)
            if (i == int'(f)) r = v[i];
        return r;
    endfunction

    function automatic logic any_ahead(input logic [N-1:0] v, input logic [3:0] f, input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N; i++)
            if (up ? (i > int'(f)) : (i < int'(f))) r = r | v[i];
        return r;
    endfunction

    always_comb begin
        rise_in    = btn_in & ~in_prev_q & {N{~buttons_block}};
        rise_up    = btn_up_out & ~up_prev_q & {(N-1){~buttons_block}};
        rise_dn    = btn_down_out & ~dn_prev_q & {(N-1){~buttons_block}};
        calls      = req_in_q | {1'b0, req_up_q} | {req_dn_q, 1'b0};
        press      = rise_in | {1'b0, rise_up} | {rise_dn, 1'b0};
        stopped    = (state_q == IDLE) || (state_q == CLOSE) ||
                     (state_q == OPEN_D) || (state_q == DWELL);
        // a press for the floor the car is parked at reopens instead of latching
        here_press = stopped && bit_at(press, level_q);
        in_prev_d  = btn_in;
        up_prev_d  = btn_up_out;
        dn_prev_d  = btn_down_out;
        bell_out_d = bell;
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        dir_d   = dir_q;
        moved_d = moved_q;
        timer_d = '0;
        serve   = 1'b0;
        arrive  = 1'b0;
        nf      = level_q;
        case (state_q)
            IDLE: begin
                if (here_press) begin
                    state_d = OPEN_D;
                end else if (|calls) begin
                    if (!any_ahead(calls, level_q, dir_q)) dir_d = ~dir_q;
                    state_d = bit_at(calls, level_q) ? OPEN_D : MOVE;
                    moved_d = 1'b0;
                end
            end
            CLOSE: begin
                timer_d = timer_q + TW'(1);
                if (overload || sensor_inside || open_btn || here_press) begin
                    state_d = OPEN_D;
                    timer_d = '0;
                end else if (sensor_door == 2'b10) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == T_IDLE) begin
                    state_d = OPEN_D;
                    timer_d = '0;
                end
            end
            MOVE: begin
                if (dir_q && sensor_up && level_q != TOP) begin
                    nf     = level_q + 4'd1;
                    arrive = 1'b1;
                end else if (!dir_q && sensor_down && level_q != 4'd0) begin
                    nf     = level_q - 4'd1;
                    arrive = 1'b1;
                end
                if (arrive) begin
                    level_d = nf;
                    moved_d = 1'b1;
                    if (bit_at(req_in_q, nf) ||
                        bit_at(dir_q ? {1'b0, req_up_q} : {req_dn_q, 1'b0}, nf) ||
                        !any_ahead(calls, nf, dir_q) || nf == 4'd0 || nf == TOP)
                        state_d = WAIT;
                end else if (!moved_q && !(|calls)) begin
                    // every call withdrawn before leaving the floor: stay put
                    state_d = IDLE;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == T_WAIT) begin
                    state_d = OPEN_D;
                    timer_d = '0;
                end
            end
            OPEN_D: begin
                timer_d = timer_q + TW'(1);
                if (sensor_door == 2'b01) begin
                    serve   = 1'b1;
                    state_d = DWELL;
                    timer_d = '0;
                end else if (timer_q == T_IDLE) begin
                    state_d = DWELL;
                    timer_d = '0;
                end
            end
            DWELL: begin
                timer_d = timer_q + TW'(1);
                if (open_btn || overload || sensor_inside || here_press) begin
                    timer_d = '0;
                end else if (close_btn || timer_q == T_OPEN) begin
                    state_d = CLOSE;
                    timer_d = '0;
                end
            end
            default: state_d = CLOSE;
        endcase
        if (level_d == 4'd0)     dir_d = 1'b1;
        else if (level_d == TOP) dir_d = 1'b0;
    end

    // Serve-clear is applied first so a same-cycle cancel toggle overrides it.
    always_comb begin
        req_in_d = req_in_q;
        req_up_d = req_up_q;
        req_dn_d = req_dn_q;
        clr_up   = dir_q || (level_q == 4'd0) || !any_ahead(calls, level_q, dir_q);
        clr_dn   = !dir_q || (level_q == TOP) || !any_ahead(calls, level_q, dir_q);
        for (int i = 0; i < N; i++) begin
            if (serve && i == int'(level_q)) req_in_d[i] = 1'b0;
            if (rise_in[i] && !(stopped && i == int'(level_q))) req_in_d[i] = ~req_in_q[i];
        end
        for (int i = 0; i < N-1; i++) begin
            if (serve && clr_up && i == int'(level_q)) req_up_d[i] = 1'b0;
            if (rise_up[i] && !(stopped && i == int'(level_q))) req_up_d[i] = 1'b1;
        end
        for (int i = 1; i < N; i++) begin
            if (serve && clr_dn && i == int'(level_q)) req_dn_d[i] = 1'b0;
            if (rise_dn[i] && !(stopped && i == int'(level_q))) req_dn_d[i] = 1'b1;
        end
    end

    always_comb begin
        engine_d = 2'b00;
        if (state_d == MOVE) engine_d = dir_d ? 2'b01 : 2'b10;
        door_d = 2'b00;
        if (state_d == CLOSE)       door_d = 2'b10;
        else if (state_d == OPEN_D) door_d = 2'b01;
    end

    always_ff @(posedge clock) begin
        if (an_reset) begin
            state_q    <= CLOSE;
            level_q    <= 4'd0;
            dir_q      <= 1'b1;
            moved_q    <= 1'b0;
            timer_q    <= '0;
            engine_q   <= 2'b00;
            door_q     <= 2'b10;
            bell_out_q <= 1'b0;
            req_in_q   <= '0;
            req_up_q   <= '0;
            req_dn_q   <= '0;
            in_prev_q  <= '0;
            up_prev_q  <= '0;
            dn_prev_q  <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            dir_q      <= dir_d;
            moved_q    <= moved_d;
            timer_q    <= timer_d;
            engine_q   <= engine_d;
            door_q     <= door_d;
            bell_out_q <= bell_out_d;
            req_in_q   <= req_in_d;
            req_up_q   <= req_up_d;
            req_dn_q   <= req_dn_d;
            in_prev_q  <= in_prev_d;
            up_prev_q  <= up_prev_d;
            dn_prev_q  <= dn_prev_d;
        end
    end

    assign engine        = engine_q;
    assign door          = door_q;
    assign direction     = dir_q;
    assign bell_out      = bell_out_q;
    assign level_display = level_q;
endmodule

// File: tb/tb_elevator.sv
// Bench for elevator: plant model closes the engine/door loop; expected stop
// floors are queued with each call and compared whenever the door starts opening.
module tb_elevator;
    localparam int DI = 60;
    localparam int DW = 5;
    localparam int DO = 20;

    logic       clock = 1'b0;
    logic       an_reset = 1'b1;
    logic       buttons_block = 1'b0, open_btn = 1'b0, close_btn = 1'b0;
    logic       overload = 1'b0, bell = 1'b0, sensor_inside = 1'b0;
    logic       sensor_up = 1'b0, sensor_down = 1'b0;
    logic [1:0] sensor_door;
    logic [7:0] btn_in = '0;
    logic [6:0] btn_up_out = '0;
    logic [7:1] btn_down_out = '0;
    logic [1:0] engine, door;
    logic       direction, bell_out;
    logic [3:0] level_display;

    elevator #(.BUTTONS_WIDTH(8), .DELAY_IDLE(DI), .DELAY_WAIT(DW), .DELAY_OPEN(DO)) dut (
        .clock(clock), .an_reset(an_reset), .buttons_block(buttons_block),
        .open_btn(open_btn), .close_btn(close_btn), .overload(overload), .bell(bell),
        .sensor_up(sensor_up), .sensor_down(sensor_down), .sensor_inside(sensor_inside),
        .sensor_door(sensor_door), .btn_in(btn_in), .btn_up_out(btn_up_out),
        .btn_down_out(btn_down_out), .engine(engine), .door(door), .direction(direction),
        .bell_out(bell_out), .level_display(level_display)
    );

    always #5 clock = ~clock;

    // plant: door takes 3 cycles end to end, one floor of travel takes 8 cycles
    int dpos = 0;
    int tcnt = 0;
    assign sensor_door = (dpos == 3) ? 2'b01 : (dpos == 0) ? 2'b10 : 2'b00;
    always @(posedge clock) begin
        if (door == 2'b01 && dpos < 3) dpos <= dpos + 1;
        else if (door == 2'b10 && dpos > 0) dpos <= dpos - 1;
        sensor_up   <= 1'b0;
        sensor_down <= 1'b0;
        if (engine == 2'b00) tcnt <= 0;
        else if (tcnt == 7) begin
            tcnt <= 0;
            if (engine == 2'b01) sensor_up <= 1'b1;
            else sensor_down <= 1'b1;
        end else tcnt <= tcnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int exp_q[$];
    logic [1:0] door_prev = 2'b10;
    always @(negedge clock) begin
        if (door == 2'b01 && door_prev != 2'b01) begin
            chk("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) chk("stop_floor", int'(level_display), exp_q.pop_front());
        end
        door_prev = door;
    end

    task automatic wait_door(input logic [1:0] v, input int budget, input string tag);
        int n = 0;
        while (door !== v && n < budget) begin @(negedge clock); n++; end
        if (door !== v) chk(tag, int'(door), int'(v));
    endtask

    task automatic wait_engine(input logic [1:0] v, input int budget, input string tag);
        int n = 0;
        while (engine !== v && n < budget) begin @(negedge clock); n++; end
        if (engine !== v) chk(tag, int'(engine), int'(v));
    endtask

    task automatic wait_quiet(input int budget);
        int run = 0;
        int n = 0;
        while (run < 12 && n < budget) begin
            @(negedge clock);
            n++;
            if (door == 2'b00 && engine == 2'b00 && sensor_door == 2'b10) run++;
            else run = 0;
        end
        if (run < 12) chk("quiet_tmo", run, 12);
    endtask

    task automatic pulse(input logic [7:0] bi, input logic [6:0] bu, input logic [7:1] bd);
        btn_in = bi; btn_up_out = bu; btn_down_out = bd;
        @(negedge clock);
        btn_in = '0; btn_up_out = '0; btn_down_out = '0;
        @(negedge clock);
    endtask

    task automatic watch_still(input int cycles, input string tag);
        int moved = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (level_display != 4'd0 || engine == 2'b10) moved = 1;
        end
        chk(tag, moved, 0);
        chk({tag, "_level"}, int'(level_display), 0);
    endtask

    task automatic hold_check(input string tag);
        int closed = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (door == 2'b10) closed = 1;
        end
        chk({tag, "_no_close"}, closed, 0);
        chk({tag, "_sensor_open"}, int'(sensor_door), 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:1] d4;
        int n;
        repeat (3) @(negedge clock);
        chk("rst_level", int'(level_display), 0);
        chk("rst_engine", int'(engine), 0);
        chk("rst_door", int'(door), 2);
        chk("rst_dir", int'(direction), 1);
        chk("rst_bell", int'(bell_out), 0);
        an_reset = 1'b0;
        wait_quiet(200);

        // single car call to floor 6 with timing of settle and dwell
        exp_q.push_back(6);
        pulse(8'h40, '0, '0);
        wait_engine(2'b01, 200, "t1_go_tmo");
        chk("t1_engine_up", int'(engine), 1);
        wait_engine(2'b00, 600, "t1_stop_tmo");
        chk("t1_level", int'(level_display), 6);
        n = 0;
        while (door != 2'b01 && n < 100) begin @(negedge clock); n++; end
        chk("t1_settle_cycles", n, DW);
        wait_door(2'b00, 100, "t1_dwell_tmo");
        n = 0;
        while (door != 2'b10 && n < 200) begin @(negedge clock); n++; end
        chk("t1_dwell_cycles", n, DO);
        wait_quiet(300);
        chk("t1_dir", int'(direction), 1);

        exp_q.push_back(0);
        pulse(8'h01, '0, '0);
        wait_quiet(1000);
        chk("ret_level", int'(level_display), 0);
        chk("ret_dir_bottom", int'(direction), 1);

        // every car button at once from floor 0
        for (int f = 0; f < 8; f++) exp_q.push_back(f);
        pulse(8'hFF, '0, '0);
        wait_quiet(3000);
        chk("all_level", int'(level_display), 7);
        chk("all_dir_top", int'(direction), 0);
        repeat (50) @(negedge clock);
        chk("all_cleared_engine", int'(engine), 0);
        chk("all_cleared_level", int'(level_display), 7);

        // hall calls: up to 3, then car 6 beats hall-down 4, then home
        exp_q.push_back(0);
        pulse(8'h01, '0, '0);
        wait_quiet(1500);
        chk("s3_home", int'(level_display), 0);
        exp_q.push_back(3);
        pulse('0, 7'h08, '0);
        wait_quiet(1000);
        chk("s3_at3", int'(level_display), 3);
        exp_q.push_back(6);
        exp_q.push_back(4);
        d4 = '0;
        d4[4] = 1'b1;
        pulse(8'h40, '0, d4);
        wait_engine(2'b10, 1000, "s3_turn_tmo");
        chk("s3_turn_level", int'(level_display), 6);
        chk("s3_dir_down", int'(direction), 0);
        wait_quiet(1000);
        chk("s3_at4", int'(level_display), 4);
        exp_q.push_back(0);
        pulse(8'h01, '0, '0);
        wait_quiet(1000);
        chk("s3_end", int'(level_display), 0);

        // open_btn holds the dwell; release restarts the full dwell
        exp_q.push_back(0);
        pulse('0, 7'h01, '0);
        wait_door(2'b01, 50, "ob_open_tmo");
        wait_door(2'b00, 100, "ob_dwell_tmo");
        open_btn = 1'b1;
        hold_check("ob_hold");
        open_btn = 1'b0;
        n = 0;
        while (door != 2'b10 && n < 200) begin @(negedge clock); n++; end
        chk("ob_release_cycles", n, DO);
        wait_quiet(300);

        exp_q.push_back(0);
        pulse('0, 7'h01, '0);
        wait_door(2'b01, 50, "cb_open_tmo");
        wait_door(2'b00, 100, "cb_dwell_tmo");
        @(negedge clock);
        close_btn = 1'b1;
        @(negedge clock);
        chk("cb_door_close", int'(door), 2);
        close_btn = 1'b0;
        wait_quiet(300);

        // double press cancels; blocked presses ignored
        btn_in = 8'h20; @(negedge clock);
        btn_in = '0;    @(negedge clock);
        btn_in = 8'h20; @(negedge clock);
        btn_in = '0;
        watch_still(100, "cancel_still");
        buttons_block = 1'b1;
        pulse(8'h08, 7'h10, '0);
        buttons_block = 1'b0;
        watch_still(100, "block_still");

        // overload and obstruction during closing
        exp_q.push_back(0);
        pulse('0, 7'h01, '0);
        wait_door(2'b01, 50, "ov_open_tmo");
        wait_door(2'b00, 100, "ov_dwell_tmo");
        wait_door(2'b10, 200, "ov_close_tmo");
        exp_q.push_back(0);
        overload = 1'b1;
        @(negedge clock);
        chk("ov_reopen", int'(door), 1);
        hold_check("ov_hold");
        overload = 1'b0;
        wait_quiet(400);

        exp_q.push_back(0);
        pulse('0, 7'h01, '0);
        wait_door(2'b01, 50, "si_open_tmo");
        wait_door(2'b00, 100, "si_dwell_tmo");
        wait_door(2'b10, 200, "si_close_tmo");
        exp_q.push_back(0);
        sensor_inside = 1'b1;
        @(negedge clock);
        chk("si_reopen", int'(door), 1);
        hold_check("si_hold");
        sensor_inside = 1'b0;
        wait_quiet(400);

        // bell passthrough, one cycle late
        for (int k = 0; k < 310; k++) begin
            bell = (k < 300);
            @(negedge clock);
            chk("bell_out", int'(bell_out), (k < 300) ? 1 : 0);
        end

        repeat (20) @(negedge clock);
        chk("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/elevator.md
Name: elevator

Overview:
- Single-car collective controller for an N-floor elevator (default 8 floors, 0..7).
- Latches car and hall calls, picks a travel direction, and drives the engine and door actuators. It uses floor-arrival and door-position feedback from a plant model (test_module) that closes the loop on engine/door.
- Also provides a floor display, a direction indicator and a bell passthrough.

Parameters:
- BUTTONS_WIDTH, 8: number of floors; floor index 0..BUTTONS_WIDTH-1 (≤16).
- DELAY_IDLE, 5000: door feedback timeout in clock cycles.
- DELAY_WAIT, 500: settle cycles between engine stop and door-open command.
- DELAY_OPEN, 6000: door dwell cycles once fully open.

Ports:
- clock  in  1  system clock, all state on rising edge.
- an_reset  in  1  reset; synchronous, active-high.
- buttons_block  in  1  1 = ignore new call presses (pending calls kept).
- open_btn  in  1  door-open request (level).
- close_btn  in  1  door-close request (level).
- overload  in  1  car overloaded; inhibits closing/travel.
- bell  in  1  alarm button.
- sensor_up  in  1  pulse: car arrived at next floor while moving up.
- sensor_down  in  1  pulse: car arrived at next floor while moving down.
- sensor_inside  in  1  obstruction in doorway; inhibits closing.
- sensor_door  in  2  01 = fully open, 10 = fully closed, 00 = in motion.
- btn_in  in  BUTTONS_WIDTH  car buttons, bit i = floor i.
- btn_up_out  in  BUTTONS_WIDTH-1  hall up calls, floors 0..N-2.
- btn_down_out  in  BUTTONS_WIDTH-1  hall down calls, floors 1..N-1 (index [N-1:1]).
- engine  out  2  00 stop, 01 up, 10 down (11 never driven).
- door  out  2  00 hold, 01 open, 10 close (11 never driven).
- direction  out  1  1 = up / last up, 0 = down.
- bell_out  out  1  registered copy of bell.
- level_display  out  4  current floor, binary.

Behaviour:
- Reset (an_reset=1 at a clock edge):
  - All request registers cleared.
  - level_display=0, engine=00, door=10, direction=1, bell_out=0, timers 0.
  - State goes to CLOSE. Car is taken to be at floor 0.
- Call latching:
  - Rising edge of any button bit, and buttons_block=0: set the matching pending bit.
  - A second rising edge on an already pending btn_in bit cancels it (toggle). Hall bits only set.
  - A press for the current floor while stopped in OPEN/CLOSE: no latch; door reopens.
- States: IDLE, CLOSE, MOVE, WAIT, OPEN_D, DWELL.
- IDLE (door closed, engine 00, door 00):
  - If a call exists, pick the direction: keep current direction if any call lies beyond the current floor in that direction, else reverse.
  - If a call is at the current floor, go to OPEN_D; otherwise go to MOVE.
- CLOSE:
  - door=10 until sensor_door=10, then go to IDLE.
  - overload, sensor_inside or open_btn go to OPEN_D.
  - If not closed within DELAY_IDLE cycles, go to OPEN_D.
- MOVE:
  - engine=01 (up) or 10 (down), door=00.
  - On sensor_up/sensor_down, increment/decrement level_display at the same edge.
  - Stop condition at the new floor: btn_in pending; or a hall call in the current direction pending; or no further calls ahead (then take the opposite-direction hall call). Floor 0 and floor N-1 always stop.
  - On stop: engine=00 next cycle, go to WAIT. Level never leaves 0..N-1; the opposite sensor is ignored.
- WAIT: DELAY_WAIT cycles with engine=00, then go to OPEN_D.
- OPEN_D:
  - door=01 until sensor_door=01.
  - Clear btn_in[floor] plus the served hall call(s) for the current direction, then go to DWELL.
  - DELAY_IDLE timeout also goes to DWELL.
- DWELL:
  - door=00; count DELAY_OPEN cycles, then go to CLOSE.
  - open_btn, overload or sensor_inside held: counter stays reset.
  - close_btn (with none of those active): go to CLOSE immediately.
- Direction update: direction follows the engine command. At the top floor it forces 0, at floor 0 it forces 1.
- Simultaneous events: reset dominates everything; cancel-toggle dominates the serve-clear in the same cycle.
- bell_out <= bell every cycle; independent of state.

Test Plan:
- Reset, then btn_in[6] pulse:
  - Door closes, then engine=01.
  - level_display 0→6 on six sensor_up pulses, then engine=00.
  - After 500 cycles door=01; dwell 6000 cycles; door=10.
- From floor 0, all btn_in bits pulsed at once: car stops at every floor 1..7 in order, each with an open/dwell/close cycle; all pending bits cleared.
- Car idle at floor 0:
  - btn_up_out[3] pulse: car serves floor 3.
  - Then btn_in[6] and btn_down_out[4] pulses: car goes up to 6 first, then down, stopping at 4.
  - Then btn_in[0] pulse: car ends at 0.
- Doors open at a floor:
  - Hold open_btn: door stays open beyond 6000 cycles.
  - Release open_btn: close after 6000 cycles.
  - close_btn in DWELL: door=10 next cycle.
- btn_in[5] pressed twice in IDLE at floor 0: request cancelled, car never moves; buttons_block=1 presses are ignored.
- overload or sensor_inside asserted during CLOSE: door returns to 01 and stays open while the input is held. Bell pulse of 300 cycles gives bell_out the same width, delayed 1 cycle.
